// File: rtl/clk_rst_gen.sv
// Clock-enable divider plus reset sequencer with button input and reset stretching.
// Define CLKRST_DEBOUNCE_EN to add a DEB_CYCLES stability filter on the synchronized button.
module clk_rst_gen #(
    parameter int unsigned DIV_W      = 4,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned DEB_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             nBut,
    input  logic [DIV_W-1:0] div_sel,
    output logic             clk_en,
    output logic             clk_div,
    output logic             reset,
    output logic [1:0]       state
);

    localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned THR_W = DIV_W + 1;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_COUNT = 2'd1,
        S_RUN   = 2'd2
    } seq_e;

    if (RST_CYCLES == 0 || DEB_CYCLES == 0) begin : g_param_chk
        $error("clk_rst_gen: RST_CYCLES and DEB_CYCLES must be nonzero");
    end

    // Two-flop synchronizer; idles at released.
    logic but_m;
    logic but_s;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            but_m <= 1'b1;
            but_s <= 1'b1;
        end else begin
            but_m <= nBut;
            but_s <= but_m;
        end
    end

    logic but_f;

`ifdef CLKRST_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] deb_cnt;

    // Accept a new level only after it has differed from the filtered one for DEB_CYCLES cycles.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            deb_cnt <= '0;
            but_f   <= 1'b1;
        end else if (but_s == but_f) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_cnt <= '0;
            but_f   <= but_s;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end
`else
    assign but_f = but_s;
`endif

    // Reset sequencer.
    seq_e             st_q;
    seq_e             st_d;
    logic [CNT_W-1:0] str_q;
    logic [CNT_W-1:0] str_d;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            st_q  <= S_HOLD;
            str_q <= '0;
            reset <= 1'b1;
        end else begin
            st_q  <= st_d;
            str_q <= str_d;
            reset <= (st_d != S_RUN);
        end
    end

    always_comb begin
        st_d  = st_q;
        str_d = str_q;
        unique case (st_q)
            S_HOLD: begin
                if (but_f) begin
                    st_d  = S_COUNT;
                    str_d = '0;
                end
            end
            S_COUNT: begin
                if (!but_f) begin
                    st_d  = S_HOLD;
                    str_d = '0;
                end else if (str_q == CNT_W'(RST_CYCLES - 1)) begin
                    st_d = S_RUN;
                end else begin
                    str_d = str_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!but_f) begin
                    st_d  = S_HOLD;
                    str_d = '0;
                end
            end
            default: begin
                st_d  = S_HOLD;
                str_d = '0;
            end
        endcase
    end

    assign state = st_q;

    // Divider: ratio is only reloaded at wrap (or while in reset), so periods never get cut.
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] sel_q;
    logic [DIV_W-1:0] sel_d;
    logic [THR_W-1:0] thr;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q >= sel_q);
        cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        sel_d = (wrap || reset) ? div_sel : sel_q;
        thr   = (THR_W'(sel_d) + THR_W'(2)) >> 1;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            clk_en  <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            clk_en  <= (cnt_d >= sel_d);
            clk_div <= (THR_W'(cnt_d) >= thr);
        end
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Scoreboard bench for clk_rst_gen: stimulus queues expected outputs, a negedge monitor checks them.
module tb_clk_rst_gen;

`ifdef CLKRST_DEBOUNCE_EN
    localparam int PL = 11;
`else
    localparam int PL = 3;
`endif

    logic       clk;
    logic       nReset;
    logic       nBut;
    logic [3:0] div_sel;
    logic       clk_en;
    logic       clk_div;
    logic       reset;
    logic [1:0] state;

    clk_rst_gen #(
        .DIV_W      (4),
        .RST_CYCLES (16),
        .DEB_CYCLES (8)
    ) dut (
        .clk     (clk),
        .nReset  (nReset),
        .nBut    (nBut),
        .div_sel (div_sel),
        .clk_en  (clk_en),
        .clk_div (clk_div),
        .reset   (reset),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // m selects which fields are compared: {state, reset, clk_en, clk_div}.
    typedef struct packed {
        logic [3:0] m;
        logic [1:0] st;
        logic       rst;
        logic       en;
        logic       dv;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s (check %0d): got %0d, want %0d", nm, n_chk, act, req);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.m[3]) chk("state",   32'(state),   32'(e.st));
            if (e.m[2]) chk("reset",   32'(reset),   32'(e.rst));
            if (e.m[1]) chk("clk_en",  32'(clk_en),  32'(e.en));
            if (e.m[0]) chk("clk_div", 32'(clk_div), 32'(e.dv));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] m, input logic [1:0] st, input logic rst,
                        input logic en, input logic dv);
        exp_t x;
        x.m   = m;
        x.st  = st;
        x.rst = rst;
        x.en  = en;
        x.dv  = dv;
        q.push_back(x);
    endtask

    task automatic run_state(input int n, input logic [1:0] st, input logic rst);
        for (int i = 0; i < n; i++) begin
            cyc();
            push(4'b1100, st, rst, 1'b0, 1'b0);
        end
    endtask

    // Press from RUN, hold 12 cycles, release, expect a full 16-cycle stretch.
    task automatic button_reset();
        nBut = 1'b0;
        run_state(PL - 1, 2'd2, 1'b0);
        run_state(13 - PL, 2'd0, 1'b1);
        nBut = 1'b1;
        run_state(PL - 1, 2'd0, 1'b1);
        run_state(16, 2'd1, 1'b1);
        run_state(2, 2'd2, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [9:0] en_v;
    logic [9:0] dv_v;
    int         c;

    initial begin
        nReset  = 1'b0;
        nBut    = 1'b1;
        div_sel = 4'd3;
        en_v    = 10'b11_1111_1000;
        dv_v    = 10'b00_0000_1100;

        // Power-up: reset values while nReset is held.
        for (int i = 0; i < 3; i++) begin
            cyc();
            push(4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
        end
        nReset = 1'b1;

        // 16 COUNT cycles then RUN; divide-by-4 pattern.
        for (int k = 1; k <= 24; k++) begin
            cyc();
            c = (k - 1) % 4;
            if (k <= 16) push(4'b1100, 2'd1, 1'b1, 1'b0, 1'b0);
            else         push(4'b1111, 2'd2, 1'b0, c == 3, c >= 2);
        end

        // Divide-by-5 takes effect at the next wrap (counter is at 3 now).
        div_sel = 4'd4;
        for (int m = 0; m < 10; m++) begin
            cyc();
            c = m % 5;
            push(4'b1111, 2'd2, 1'b0, c == 4, c >= 3);
        end

        // Back to ratio 4, then switch to ratio 1 at counter 1: period still completes.
        div_sel = 4'd3;
        for (int i = 0; i < 10; i++) begin
            cyc();
            push(4'b1111, 2'd2, 1'b0, en_v[i], dv_v[i]);
            if (i == 1) div_sel = 4'd0;
        end

`ifdef CLKRST_DEBOUNCE_EN
        // Short bounce is filtered out.
        nBut = 1'b0;
        run_state(5, 2'd2, 1'b0);
        nBut = 1'b1;
        run_state(12, 2'd2, 1'b0);
`endif

        button_reset();

        // Re-press while counting: back to HOLD at stretch count 10, then full stretch again.
        nBut = 1'b0;
        run_state(PL - 1, 2'd2, 1'b0);
        run_state(13 - PL, 2'd0, 1'b1);
        nBut = 1'b1;
        run_state(PL - 1, 2'd0, 1'b1);
        run_state(12 - PL, 2'd1, 1'b1);
        nBut = 1'b0;
        run_state(PL - 1, 2'd1, 1'b1);
        run_state(13 - PL, 2'd0, 1'b1);
        nBut = 1'b1;
        run_state(PL - 1, 2'd0, 1'b1);
        run_state(16, 2'd1, 1'b1);
        run_state(2, 2'd2, 1'b0);

        // Async reset between edges while in RUN with clk_en high.
        cyc();
        push(4'b1111, 2'd2, 1'b0, 1'b1, 1'b0);
        cyc();
        #1;
        nReset = 1'b0;
        push(4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        push(4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
        nReset = 1'b1;
        run_state(16, 2'd1, 1'b1);
        run_state(3, 2'd2, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_rst_gen.md
CLK_RST_GEN -- requirements
Module: clk_rst_gen

Interface
REQ-001 SHALL provide parameter DIV_W, default 4, width of the divide-ratio select and divider counter.
REQ-002 SHALL provide parameter RST_CYCLES, default 16, number of clk cycles that reset stays asserted after every reset source releases.
REQ-003 SHALL provide parameter DEB_CYCLES, default 1024, number of clk cycles the manual button input must be stable before a change is accepted.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-006 Port: nReset  input  1  asynchronous active-low reset.
REQ-007 Port: nBut  input  1  asynchronous active-low manual reset button.
REQ-008 Port: div_sel  input  DIV_W  divide ratio minus one; ratio = div_sel+1.
REQ-009 Port: clk_en  output  1  one-cycle strobe, once per divided period.
REQ-010 Port: clk_div  output  1  divided clock-shaped signal, registered.
REQ-011 Port: reset  output  1  active-high reset for downstream modules, synchronous deassert.
REQ-012 Port: state  output  2  current sequencer state: 0 HOLD, 1 COUNT, 2 RUN.

Function
REQ-013 Divider counter SHALL count 0..ratio-1, then wrap to 0; clk_en SHALL be 1 exactly in cycles where counter = ratio-1.
REQ-014 div_sel SHALL be latched into an internal ratio register only at wrap (counter = ratio-1) or while reset = 1; mid-period changes SHALL NOT shorten or lengthen the current period.
REQ-015 clk_div SHALL be 1 when counter >= ceil(ratio/2), else 0; for ratio = 1, clk_div SHALL be constant 0 and clk_en constant 1.
REQ-016 Divider SHALL run in all sequencer states; only nReset stops it.
REQ-017 nBut SHALL pass a two-flop synchronizer before any use.
REQ-018 Sequencer HOLD: reset = 1; exit to COUNT when the filtered button is released, clearing the stretch counter.
REQ-019 Sequencer COUNT: reset = 1; stretch counter increments each cycle; at RST_CYCLES-1 go to RUN.
REQ-020 Sequencer COUNT: button pressed again SHALL return to HOLD, clearing the stretch counter.
REQ-021 Sequencer RUN: reset = 0; filtered button press SHALL go to HOLD, reset = 1 the next cycle.
REQ-022 reset SHALL be a registered output, glitch-free, deasserting on the clock edge that enters RUN.
REQ-023 Stretch counter width SHALL be clog2(RST_CYCLES), minimum 1; RST_CYCLES = 1 gives one COUNT cycle.

Reset
REQ-024 nReset low SHALL asynchronously force: state HOLD, reset = 1, clk_en = 0, clk_div = 0, divider counter 0, stretch counter 0, synchronizer and filter flops to released (1).
REQ-025 On nReset release, sequencer SHALL leave HOLD after the synchronized button reads released, then run REQ-019.
REQ-026 nReset asserted in any state, mid-count or mid-period, SHALL restart from REQ-024 values.

Configuration
REQ-027 Macro CLKRST_DEBOUNCE_EN defined: a synchronized button change SHALL be accepted only after DEB_CYCLES consecutive stable cycles; any bounce restarts the filter counter.
REQ-028 Macro CLKRST_DEBOUNCE_EN undefined: the filtered button SHALL equal the synchronizer output; DEB_CYCLES unused, no filter counter synthesized.

Verification
REQ-029 Power-up: nReset low 3 cycles, then high, nBut = 1, RST_CYCLES = 16 -> reset = 1 until exactly 16 COUNT cycles elapse, state goes 0,1,2.
REQ-030 Divider: div_sel = 3 -> clk_en high every 4th cycle, clk_div pattern 0,0,1,1; div_sel = 4 -> period 5, clk_div 0,0,0,1,1.
REQ-031 Ratio change: div_sel switched 3 -> 0 at counter = 1 -> current period still 4 cycles, then clk_en constant 1.
REQ-032 Button with CLKRST_DEBOUNCE_EN, DEB_CYCLES = 8: 5-cycle nBut low pulse -> no reset; 12-cycle low -> HOLD, reset = 1, then 16 COUNT cycles after filtered release.
REQ-033 Re-press in COUNT: filtered press at stretch count 10 -> state HOLD, count cleared, full 16 cycles after next release.
REQ-034 Async reset in RUN mid-period: nReset low between edges -> reset, clk_en, clk_div, state take REQ-024 values without waiting for clk.
